// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit:
// size codes, error codes, FSM encoding and the alignment rule.
package lsu_pkg;

    localparam logic [1:0] LS_B = 2'b00;
    localparam logic [1:0] LS_H = 2'b01;
    localparam logic [1:0] LS_W = 2'b10;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ALIGN   = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    // Size 11 has no legal alignment, so it reports as misaligned.
    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        case (size)
            LS_B:    return 1'b0;
            LS_H:    return off[0];
            LS_W:    return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_handshake_if.sv
// Core-side and memory-side handshake bundles of the load/store unit.
// master drives the request, slave answers it.
interface lsu_core_if #(
    parameter int ADDR_W = 32
);
    logic              ls_req;
    logic              ls_we;
    logic [2:0]        ls_op;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_ready;
    logic              ls_done;
    logic [31:0]       ls_rdata;
    logic [1:0]        ls_err;

    modport master (
        output ls_req, ls_we, ls_op, ls_addr, ls_wdata,
        input  ls_ready, ls_done, ls_rdata, ls_err
    );

    modport slave (
        input  ls_req, ls_we, ls_op, ls_addr, ls_wdata,
        output ls_ready, ls_done, ls_rdata, ls_err
    );
endinterface

interface lsu_mem_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/lsu_lane.sv
// Byte-lane steering: store byte enables / replicated data,
// and load extraction with sign or zero extension.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [1:0]  ld_size_i,
    input  logic        ld_uns_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = st_data_i;
        unique case (st_size_i)
            LS_B: begin
                be_o    = 4'b0001 << st_off_i;
                wdata_o = {4{st_data_i[7:0]}};
            end
            LS_H: begin
                be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{st_data_i[15:0]}};
            end
            LS_W: begin
                be_o    = 4'b1111;
            end
            default: begin
                be_o    = 4'b0000;
            end
        endcase
    end

    always_comb begin
        ld_byte   = ld_word_i[{ld_off_i, 3'b000} +: 8];
        ld_half   = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        ld_data_o = 32'h0;
        unique case (ld_size_i)
            LS_B:    ld_data_o = {{24{~ld_uns_i & ld_byte[7]}}, ld_byte};
            LS_H:    ld_data_o = {{16{~ld_uns_i & ld_half[15]}}, ld_half};
            LS_W:    ld_data_o = ld_word_i;
            default: ld_data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_handshake.sv
// Multi-cycle load/store unit: IDLE -> ACCESS -> RESP handshake
// towards a req/ack data memory, with alignment check and ack timeout.
module lsu_handshake
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic      clk,
    input  logic      reset,
    lsu_core_if.slave core,
    lsu_mem_if.master mem
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e            state_q;
    err_e              err_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        off_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ready_q;
    logic              done_q;
    logic [31:0]       rdata_q;
    logic              req_q;
    logic              mwe_q;
    logic [3:0]        be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [3:0]        st_be;
    logic [31:0]       st_wdata;
    logic [31:0]       ld_data;
    logic              misal;

    assign misal = misaligned(core.ls_op[1:0], core.ls_addr[1:0]);

    lsu_lane u_lane (
        .st_size_i (core.ls_op[1:0]),
        .st_off_i  (core.ls_addr[1:0]),
        .st_data_i (core.ls_wdata),
        .be_o      (st_be),
        .wdata_o   (st_wdata),
        .ld_size_i (size_q),
        .ld_uns_i  (uns_q),
        .ld_off_i  (off_q),
        .ld_word_i (mem.mem_rdata),
        .ld_data_o (ld_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            err_q   <= ERR_NONE;
            we_q    <= 1'b0;
            size_q  <= LS_B;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            rdata_q <= 32'h0;
            req_q   <= 1'b0;
            mwe_q   <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (core.ls_req) begin
                        we_q    <= core.ls_we;
                        size_q  <= core.ls_op[1:0];
                        uns_q   <= core.ls_op[2];
                        off_q   <= core.ls_addr[1:0];
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        if (misal) begin
                            state_q <= ST_RESP;
                            done_q  <= 1'b1;
                            rdata_q <= 32'h0;
                            err_q   <= ERR_ALIGN;
                        end else begin
                            state_q <= ST_ACCESS;
                            req_q   <= 1'b1;
                            mwe_q   <= core.ls_we;
                            be_q    <= st_be;
                            addr_q  <= {core.ls_addr[ADDR_W-1:2], 2'b00};
                            wdata_q <= st_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    // An ack in the final timeout cycle still wins.
                    if (mem.mem_ack) begin
                        state_q <= ST_RESP;
                        done_q  <= 1'b1;
                        rdata_q <= we_q ? 32'h0 : ld_data;
                        err_q   <= ERR_NONE;
                        req_q   <= 1'b0;
                        mwe_q   <= 1'b0;
                        be_q    <= 4'b0000;
                    end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                        state_q <= ST_RESP;
                        done_q  <= 1'b1;
                        rdata_q <= 32'h0;
                        err_q   <= ERR_TIMEOUT;
                        req_q   <= 1'b0;
                        mwe_q   <= 1'b0;
                        be_q    <= 4'b0000;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign core.ls_ready = ready_q;
    assign core.ls_done  = done_q;
    assign core.ls_rdata = rdata_q;
    assign core.ls_err   = err_q;

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = mwe_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_handshake.sv
// Directed bench: a default-timeout unit (d) for the vector table
// and a TIMEOUT=4 unit (t) for the timeout corner cases.
module tb_lsu_handshake;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wd = 32'h0;
    logic [31:0] mrd = 32'h0;
    logic        ack = 1'b0;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_core_if cd ();
    lsu_mem_if  md ();
    lsu_core_if ct ();
    lsu_mem_if  mt ();

    assign cd.ls_req   = req;
    assign cd.ls_we    = we;
    assign cd.ls_op    = op;
    assign cd.ls_addr  = addr;
    assign cd.ls_wdata = wd;
    assign ct.ls_req   = req;
    assign ct.ls_we    = we;
    assign ct.ls_op    = op;
    assign ct.ls_addr  = addr;
    assign ct.ls_wdata = wd;
    assign md.mem_rdata = mrd;
    assign md.mem_ack   = ack;
    assign mt.mem_rdata = mrd;
    assign mt.mem_ack   = ack;

    lsu_handshake u_d (
        .clk   (clk),
        .reset (rst_n),
        .core  (cd.slave),
        .mem   (md.master)
    );

    lsu_handshake #(.TIMEOUT(4)) u_t (
        .clk   (clk),
        .reset (rst_n),
        .core  (ct.slave),
        .mem   (mt.master)
    );

    typedef struct {
        string       nm;
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          k;
        logic [3:0]  be;
        logic [31:0] mwd;
        logic [31:0] rdata;
        logic [1:0]  err;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s.%s: got %h want %h", nm, fld, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(cd.ls_ready && ct.ls_ready) && n < 40) begin
            step();
            n++;
        end
        chk("idle", "ready", 32'(cd.ls_ready && ct.ls_ready), 32'd1);
    endtask

    task automatic issue(input logic w, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] d);
        wait_idle();
        req = 1'b1; we = w; op = o; addr = a; wd = d;
        step();
        req = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        issue(v.we, v.op, v.addr, v.wd);
        if (v.err != 2'b00) begin
            chk(v.nm, "done", 32'(cd.ls_done), 32'd1);
            chk(v.nm, "err", 32'(cd.ls_err), 32'(v.err));
            chk(v.nm, "rdata", cd.ls_rdata, 32'h0);
            chk(v.nm, "mem_req", 32'(md.mem_req), 32'd0);
        end else begin
            for (int c = 1; c <= v.k; c++) begin
                chk(v.nm, "mem_req", 32'(md.mem_req), 32'd1);
                chk(v.nm, "mem_be", 32'(md.mem_be), 32'(v.be));
                chk(v.nm, "done_early", 32'(cd.ls_done), 32'd0);
                if (c == 1) begin
                    chk(v.nm, "mem_we", 32'(md.mem_we), 32'(v.we));
                    chk(v.nm, "mem_addr", md.mem_addr, v.addr & 32'hFFFF_FFFC);
                end
                if (v.we) chk(v.nm, "mem_wdata", md.mem_wdata, v.mwd);
                if (c == v.k) begin
                    ack = 1'b1;
                    mrd = v.rd;
                end
                step();
            end
            ack = 1'b0;
            mrd = 32'h5A5A_5A5A;
            chk(v.nm, "done", 32'(cd.ls_done), 32'd1);
            chk(v.nm, "rdata", cd.ls_rdata, v.rdata);
            chk(v.nm, "err", 32'(cd.ls_err), 32'd0);
            chk(v.nm, "mem_req_drop", 32'(md.mem_req), 32'd0);
            chk(v.nm, "mem_be_drop", 32'(md.mem_be), 32'd0);
        end
        step();
        chk(v.nm, "done_pulse", 32'(cd.ls_done), 32'd0);
    endtask

    initial begin
        int dones;

        vecs[0]  = '{"lb_neg", 1'b0, 3'b000, 32'h1003, 32'h0, 32'h80AA5511, 1,
                     4'b1000, 32'h0, 32'hFFFFFF80, 2'b00};
        vecs[1]  = '{"lbu", 1'b0, 3'b100, 32'h1003, 32'h0, 32'h80AA5511, 1,
                     4'b1000, 32'h0, 32'h00000080, 2'b00};
        vecs[2]  = '{"lh_neg", 1'b0, 3'b001, 32'h1002, 32'h0, 32'h80017FFF, 1,
                     4'b1100, 32'h0, 32'hFFFF8001, 2'b00};
        vecs[3]  = '{"lhu", 1'b0, 3'b101, 32'h1002, 32'h0, 32'h80017FFF, 1,
                     4'b1100, 32'h0, 32'h00008001, 2'b00};
        vecs[4]  = '{"lw", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h80017FFF, 2,
                     4'b1111, 32'h0, 32'h80017FFF, 2'b00};
        vecs[5]  = '{"lb_pos", 1'b0, 3'b000, 32'h1001, 32'h0, 32'h80AA5511, 1,
                     4'b0010, 32'h0, 32'h00000055, 2'b00};
        vecs[6]  = '{"lh_lo", 1'b0, 3'b001, 32'h1000, 32'h0, 32'h80017FFF, 3,
                     4'b0011, 32'h0, 32'h00007FFF, 2'b00};
        vecs[7]  = '{"lw_mis", 1'b0, 3'b010, 32'h3002, 32'h0, 32'h0, 0,
                     4'b0000, 32'h0, 32'h0, 2'b01};
        vecs[8]  = '{"lh_mis", 1'b0, 3'b001, 32'h3001, 32'h0, 32'h0, 0,
                     4'b0000, 32'h0, 32'h0, 2'b01};
        vecs[9]  = '{"sz_ill", 1'b0, 3'b011, 32'h3000, 32'h0, 32'h0, 0,
                     4'b0000, 32'h0, 32'h0, 2'b01};
        vecs[10] = '{"sw_mis", 1'b1, 3'b010, 32'h2001, 32'h11223344, 32'h0, 0,
                     4'b0000, 32'h0, 32'h0, 2'b01};
        vecs[11] = '{"sb", 1'b1, 3'b000, 32'h2001, 32'h123456A5, 32'hDEADBEEF, 1,
                     4'b0010, 32'hA5A5A5A5, 32'h0, 2'b00};
        vecs[12] = '{"sh", 1'b1, 3'b001, 32'h2002, 32'h0000BEEF, 32'hDEADBEEF, 5,
                     4'b1100, 32'hBEEFBEEF, 32'h0, 2'b00};
        vecs[13] = '{"sb_u", 1'b1, 3'b100, 32'h2003, 32'h000000C3, 32'hDEADBEEF, 1,
                     4'b1000, 32'hC3C3C3C3, 32'h0, 2'b00};
        vecs[14] = '{"sw", 1'b1, 3'b010, 32'h2004, 32'hCAFEF00D, 32'hDEADBEEF, 2,
                     4'b1111, 32'hCAFEF00D, 32'h0, 2'b00};

        rst_n = 1'b0;
        repeat (3) step();
        chk("reset", "ready", 32'(cd.ls_ready), 32'd1);
        chk("reset", "done", 32'(cd.ls_done), 32'd0);
        chk("reset", "rdata", cd.ls_rdata, 32'h0);
        chk("reset", "err", 32'(cd.ls_err), 32'd0);
        chk("reset", "mem_req", 32'(md.mem_req), 32'd0);
        chk("reset", "mem_we", 32'(md.mem_we), 32'd0);
        chk("reset", "mem_be", 32'(md.mem_be), 32'd0);
        chk("reset", "mem_addr", md.mem_addr, 32'h0);
        chk("reset", "mem_wdata", md.mem_wdata, 32'h0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // Leave a non-zero result behind so the timeout's rdata=0 shows.
        run_vec(vecs[0]);

        // No ack: TIMEOUT=4 keeps mem_req up for cycles 1..4.
        issue(1'b0, 3'b010, 32'h4000, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            chk("tmo", "mem_req", 32'(mt.mem_req), 32'd1);
            chk("tmo", "done_early", 32'(ct.ls_done), 32'd0);
            step();
        end
        chk("tmo", "done", 32'(ct.ls_done), 32'd1);
        chk("tmo", "err", 32'(ct.ls_err), 32'd2);
        chk("tmo", "rdata", ct.ls_rdata, 32'h0);
        chk("tmo", "mem_req_drop", 32'(mt.mem_req), 32'd0);
        step();
        chk("tmo", "done_pulse", 32'(ct.ls_done), 32'd0);

        // Ack arrives in the last timeout cycle.
        issue(1'b0, 3'b010, 32'h4000, 32'h0);
        repeat (3) step();
        chk("tmo_ack", "mem_req", 32'(mt.mem_req), 32'd1);
        ack = 1'b1;
        mrd = 32'h13579BDF;
        step();
        ack = 1'b0;
        chk("tmo_ack", "done", 32'(ct.ls_done), 32'd1);
        chk("tmo_ack", "err", 32'(ct.ls_err), 32'd0);
        chk("tmo_ack", "rdata", ct.ls_rdata, 32'h13579BDF);

        // Reset in ACCESS aborts silently; a stray ack afterwards is ignored.
        issue(1'b0, 3'b010, 32'h5000, 32'h0);
        chk("rst_acc", "mem_req", 32'(md.mem_req), 32'd1);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_acc", "mem_req_drop", 32'(md.mem_req), 32'd0);
        chk("rst_acc", "ready", 32'(cd.ls_ready), 32'd1);
        ack = 1'b1;
        mrd = 32'hFFFF0000;
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            dones += int'(cd.ls_done);
            step();
            ack = 1'b0;
        end
        chk("rst_acc", "no_done", 32'(dones), 32'd0);

        // Requests while busy are dropped, not queued.
        issue(1'b0, 3'b010, 32'h6000, 32'h0);
        req = 1'b1;
        addr = 32'h6004;
        step();
        chk("busy", "mem_addr", md.mem_addr, 32'h6000);
        step();
        ack = 1'b1;
        mrd = 32'h11112222;
        step();
        ack = 1'b0;
        chk("busy", "rdata", cd.ls_rdata, 32'h11112222);
        dones = int'(cd.ls_done);
        req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            dones += int'(cd.ls_done);
        end
        chk("busy", "one_done", 32'(dones), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_handshake.md
Name: lsu_handshake

Overview:
- Parametrised multi-cycle load/store unit replacing the fixed single-cycle half-word load path.
- Sits between the datapath (ALU address, rt store data, write-back mux) and a data memory with a req/ack handshake.
- Supports LB/LBU/LH/LHU/LW and SB/SH/SW:
  - byte-lane steering, byte enables, sign/zero extension;
  - misalignment detection;
  - ack timeout.

Parameters:
- ADDR_W, 32, byte-address width (≥3).
- TIMEOUT, 16, max cycles waiting for mem_ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (reset==0 resets on rising clk edge).
- ls_req  in  1  start access; sampled only when ls_ready=1.
- ls_we  in  1  1=store, 0=load.
- ls_op  in  3  [1:0] size (00 byte, 01 half, 10 word, 11 illegal→misaligned); [2] unsigned (loads only; ignored for stores).
- ls_addr  in  ADDR_W  byte address.
- ls_wdata  in  32  store data (rt).
- ls_ready  out  1  unit idle, may accept ls_req.
- ls_done  out  1  one-cycle completion pulse.
- ls_rdata  out  32  extended load result; valid while ls_done=1; 0 for stores and errors.
- ls_err  out  2  00 ok, 01 misaligned, 10 timeout; valid with ls_done.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  write strobe.
- mem_be  out  4  byte enables.
- mem_addr  out  ADDR_W  word-aligned address ({ls_addr[ADDR_W-1:2],2'b00}).
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read word.
- mem_ack  in  1  access complete; mem_rdata valid in the same cycle.

Behaviour:
- Reset values:
  - state=IDLE, ls_ready=1, ls_done=0, ls_rdata=0, ls_err=00;
  - mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, timeout counter=0.
- States: IDLE, ACCESS, RESP.
- IDLE, ls_req=1: latch we, op, addr[1:0], and compute be/wdata.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0, size 11): go to RESP with err=01; no memory access ever issued.
  - Otherwise: go to ACCESS; mem_req, mem_we, mem_be, mem_addr, mem_wdata all registered high/valid from the next cycle.
- ACCESS: outputs held stable while mem_ack=0; the counter increments each cycle.
  - mem_ack=1: capture and extend mem_rdata; drop mem_req/mem_we/mem_be to 0 next cycle; go to RESP with err=00.
  - TIMEOUT≠0 and counter reaches TIMEOUT-1 with no ack: drop mem_req; go to RESP with err=10 and rdata=0.
  - Ack on the same cycle as the timeout: the ack wins.
- RESP: ls_done=1 for exactly one cycle, ls_ready=0; then IDLE. ls_rdata/ls_err hold until the next access completes.
- Latency: req at cycle 0 → mem_req cycle 1 → ack cycle k≥1 → ls_done cycle k+1. Misaligned request: ls_done at cycle 1.
- ls_ready=1 only in IDLE. ls_req while not ready is ignored (not queued). mem_ack outside ACCESS is ignored.
- Load extraction, with off=addr[1:0]:
  - byte: mem_rdata[8*off+7:8*off], sign-extended from bit 7 unless unsigned;
  - half: lane addr[1]; extended from bit 15 unless unsigned;
  - word: as-is.
- Store lanes:
  - byte: be=4'b0001<<off, wdata={4{ls_wdata[7:0]}};
  - half: be=addr[1]?1100:0011, wdata={2{ls_wdata[15:0]}};
  - word: be=1111, wdata=ls_wdata.
- Loads drive the same be pattern as stores with mem_we=0.
- Reset (reset==0) in any state:
  - next state IDLE, mem_req=0 next cycle;
  - no ls_done for the aborted access; the counter clears.

Decomposition:
- Shared package lsu_pkg: size codes (LS_B=2'b00, LS_H=2'b01, LS_W=2'b10), error codes (ERR_NONE, ERR_ALIGN, ERR_TIMEOUT), state encoding.
- One combinational sub-module, lsu_lane, holding the be/wdata generation and load extraction.
- The FSM, counter and output registers live in lsu_handshake.

Test Plan:
- LB at addr 0x1003, mem_rdata=0x80AA5511, ack on cycle 1 → ls_done cycle 2, ls_rdata=0xFFFFFF80, err=00; LBU at the same address → 0x00000080.
- LH at 0x1002 with mem_rdata=0x8001_7FFF → 0xFFFF8001; LHU → 0x00008001; LW at 0x1000 → 0x80017FFF.
- SB 0x...A5 to 0x2001 → mem_be=0010, mem_wdata=0xA5A5A5A5, mem_we=1, mem_addr=0x2000; SH to 0x2002 → mem_be=1100; ack delayed 5 cycles, outputs stable until ack.
- LW at 0x3002, and LH at 0x3001 → ls_done at cycle 1, err=01, mem_req never asserted.
- TIMEOUT=4, no ack → mem_req high for cycles 1–4, ls_done cycle 5 with err=10; ack coincident with the final timeout cycle → err=00 with data.
- Reset low during ACCESS → mem_req=0 next cycle, no ls_done, ls_ready=1; ls_req while busy → ignored, exactly one ls_done.
